// File: rtl/sc_spi_xfb.sv
// sc_spi_xfb: SPI transfer buffer and command sequencer.
// It holds a 16-word TX buffer that the protocol controller reads through its
// word pointer, and a 16-word RX buffer filled from the controller's receive
// strobes. It also runs a small command FSM that launches one frame, waits for
// it to finish, drains late strobes and reports completion and sticky errors.
module sc_spi_xfb #(
  parameter int START_TMO = 8
) (
  input  logic        SPICLK,
  input  logic        SYSRST,
  // host buffer port
  input  logic        BUFWE,
  input  logic [3:0]  BUFADDR,
  input  logic [31:0] BUFWDATA,
  output logic [31:0] BUFRDATA,
  // host command handshake
  input  logic        CMDSTART,
  input  logic [8:0]  CMDDWIDTH,
  input  logic [4:0]  CMDCSSEL,
  input  logic        CMDKEEPCS,
  output logic        CMDBUSY,
  output logic        CMDDONE,
  output logic [4:0]  RXWORDS,
  output logic [2:0]  ERRSTAT,
  input  logic        ERRCLR,
  // protocol controller side
  output logic [8:0]  DWIDTH,
  output logic [4:0]  CSSEL,
  output logic        CSEXTEND,
  output logic        SPISTART,
  input  logic        SPIBUSY,
  input  logic [3:0]  TXDPT,
  output logic [31:0] TXDATA,
  input  logic [31:0] RXDATA,
  input  logic        RXVALID,
  input  logic [3:0]  RXDPT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } state_t;

  // Last value of the start-timeout counter before the timeout fires.
  localparam logic [3:0] TMO_LAST = 4'(START_TMO - 1);

  state_t      state;
  logic [3:0]  tmo_cnt;
  logic        drain_cnt;
  logic        timed_out;

  logic [31:0] txbuf [16];
  logic [31:0] rxbuf [16];

  logic        tx_we;
  logic        rx_capture;
  logic        tmo_fire;
  logic        cnt_mismatch;
  logic [4:0]  exp_words;
  logic [2:0]  err_set;

  // Host writes only land while the sequencer is idle.
  assign tx_we      = BUFWE && (state == S_IDLE);
  // Strobes count from the start request until the end of the drain window.
  assign rx_capture = RXVALID && ((state == S_START) || (state == S_BUSY) || (state == S_DRAIN));

  // The controller never raised SPIBUSY within START_TMO cycles of SPISTART.
  assign tmo_fire = (state == S_START) && !SPIBUSY && (tmo_cnt == TMO_LAST);

  // One RX word per started 32-bit slice of the frame.
  assign exp_words    = {1'b0, DWIDTH[8:5]} + 5'd1;
  assign cnt_mismatch = (state == S_DONE) && !timed_out && (RXWORDS != exp_words);

  assign err_set = {tmo_fire || cnt_mismatch, BUFWE && CMDBUSY, CMDSTART && CMDBUSY};

  // The controller sees the addressed TX word with no latency.
  assign TXDATA = txbuf[TXDPT];

  // Buffer storage writes.
  // NOTE: the buffer arrays are deliberately left out of reset, so their
  // contents survive SYSRST; only the control state below is reset.
  always_ff @(posedge SPICLK) begin
    if (tx_we) txbuf[BUFADDR] <= BUFWDATA;
    if (rx_capture) rxbuf[RXDPT] <= RXDATA;
  end

  // Command FSM, RX word counter, sticky errors and registered host read port.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values into later
  // statements of the same edge.
  always_ff @(posedge SPICLK) begin
    if (SYSRST) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      drain_cnt <= 1'b0;
      timed_out <= 1'b0;
      SPISTART  <= 1'b0;
      CMDBUSY   <= 1'b0;
      CMDDONE   <= 1'b0;
      RXWORDS   <= '0;
      ERRSTAT   <= '0;
      DWIDTH    <= '0;
      CSSEL     <= '0;
      CSEXTEND  <= 1'b0;
      BUFRDATA  <= '0;
    end else begin
      BUFRDATA <= rxbuf[BUFADDR];
      // A new error in the same cycle as ERRCLR still sets its flag.
      ERRSTAT  <= (ERRCLR ? 3'b000 : ERRSTAT) | err_set;
      CMDDONE  <= 1'b0;

      if (rx_capture && (RXWORDS != 5'd16)) RXWORDS <= RXWORDS + 5'd1;

      case (state)
        S_IDLE: begin
          if (CMDSTART) begin
            DWIDTH    <= CMDDWIDTH;
            CSSEL     <= CMDCSSEL;
            CSEXTEND  <= CMDKEEPCS;
            RXWORDS   <= '0;
            tmo_cnt   <= '0;
            timed_out <= 1'b0;
            CMDBUSY   <= 1'b1;
            SPISTART  <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          if (SPIBUSY) begin
            SPISTART <= 1'b0;
            state    <= S_BUSY;
          end else if (tmo_fire) begin
            SPISTART  <= 1'b0;
            timed_out <= 1'b1;
            CMDBUSY   <= 1'b0;
            CMDDONE   <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        S_BUSY: begin
          if (!SPIBUSY) begin
            drain_cnt <= 1'b0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Two cycles so a strobe one cycle after SPIBUSY falls is still kept.
          if (drain_cnt) begin
            CMDBUSY <= 1'b0;
            CMDDONE <= 1'b1;
            state   <= S_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
